// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding, memory geometry constants, the latched
// input beat payload and the little-endian byte-lane select helper.
package imem_pkg;

   localparam int unsigned IMEM_DEPTH_BYTES = 60;
   localparam int unsigned BYTES_PER_WORD   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } loader_state_e;

   // One accepted stream beat: instruction word plus end-of-image marker.
   typedef struct packed {
      logic [31:0] word;
      logic        last;
   } loader_beat_t;

   // Little-endian lane select: k=0 -> bits [7:0], k=3 -> bits [31:24].
   function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                            input logic [1:0]  k);
      logic [7:0] b;
      case (k)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit instruction words into a byte-wide memory
// write port, one byte per clock, little-endian (address A gets [7:0]).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse; begins a load at byte 0 (IDLE or DONE only)
//   in_valid/in_ready valid/ready handshake for in_word/in_last
//   in_word, in_last  instruction word and end-of-image marker
//   mem_we/mem_waddr/mem_wdata  registered byte write port
//   word_count        words fully written in the current load
//   load_done         held high in DONE until the next start
//   overflow          image ran past DEPTH_BYTES; held until next start
//   checksum          (only with IMEM_LOADER_CHECKSUM_EN) mod-2^32 sum of
//                     accepted words, cleared on start
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = IMEM_DEPTH_BYTES,
   parameter int unsigned AW          = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_word,
   input  logic          in_last,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [7:0]    mem_wdata,
   output logic [7:0]    word_count,
   output logic          load_done,
   output logic          overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]   checksum
`endif
);

   loader_state_e state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [1:0]    k_q, k_d;
   loader_beat_t  beat_q, beat_d;
   logic          in_ready_q, in_ready_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_waddr_q, mem_waddr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic [7:0]    word_count_q, word_count_d;
   logic          load_done_q, load_done_d;
   logic          overflow_q, overflow_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]   csum_q, csum_d;
`endif

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         k_q          <= 2'd0;
         beat_q       <= '0;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_waddr_q  <= '0;
         mem_wdata_q  <= 8'd0;
         word_count_q <= 8'd0;
         load_done_q  <= 1'b0;
         overflow_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= 32'd0;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         k_q          <= k_d;
         beat_q       <= beat_d;
         in_ready_q   <= in_ready_d;
         mem_we_q     <= mem_we_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         word_count_q <= word_count_d;
         load_done_q  <= load_done_d;
         overflow_q   <= overflow_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   // Next-state and next-output logic.
   // k_q is the lane to present next; k_q==0 in WRITE means lane 3 is
   // currently on the port, so this is the last write cycle of the word.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      k_d          = k_q;
      beat_d       = beat_q;
      in_ready_d   = 1'b0;
      mem_we_d     = 1'b0;
      mem_waddr_d  = mem_waddr_q;
      mem_wdata_d  = mem_wdata_q;
      word_count_d = word_count_q;
      load_done_d  = load_done_q;
      overflow_d   = overflow_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d       = csum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ptr_d        = '0;
               word_count_d = 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d       = 32'd0;
`endif
               in_ready_d   = 1'b1;
               state_d      = ST_ACCEPT;
            end
         end

         ST_ACCEPT: begin
            if (in_valid && in_ready_q) begin
               beat_d.word = in_word;
               beat_d.last = in_last;
               mem_we_d    = 1'b1;
               mem_waddr_d = ptr_q;
               mem_wdata_d = byte_lane(in_word, 2'd0);
               ptr_d       = ptr_q + AW'(1);
               k_d         = 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d      = csum_q + in_word;
`endif
               state_d     = ST_WRITE;
            end else begin
               in_ready_d  = 1'b1;
            end
         end

         ST_WRITE: begin
            if (k_q != 2'd0) begin
               mem_we_d    = 1'b1;
               mem_waddr_d = ptr_q;
               mem_wdata_d = byte_lane(beat_q.word, k_q);
               ptr_d       = ptr_q + AW'(1);
               k_d         = k_q + 2'd1;
            end else begin
               word_count_d = word_count_q + 8'd1;
               if (beat_q.last) begin
                  load_done_d = 1'b1;
                  state_d     = ST_DONE;
               end else if (ptr_q == AW'(DEPTH_BYTES)) begin
                  load_done_d = 1'b1;
                  overflow_d  = 1'b1;
                  state_d     = ST_DONE;
               end else begin
                  in_ready_d  = 1'b1;
                  state_d     = ST_ACCEPT;
               end
            end
         end

         ST_DONE: begin
            if (start) begin
               load_done_d  = 1'b0;
               overflow_d   = 1'b0;
               ptr_d        = '0;
               word_count_d = 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d       = 32'd0;
`endif
               in_ready_d   = 1'b1;
               state_d      = ST_ACCEPT;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign in_ready   = in_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign word_count = word_count_q;
   assign load_done  = load_done_q;
   assign overflow   = overflow_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed stimulus, scoreboard of expected
// byte writes consumed by a monitor that also models the byte RAM.
module tb_imem_loader;

   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_word;
   logic          in_last;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdata;
   logic [7:0]    word_count;
   logic          load_done;
   logic          overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   always #5 clk = ~clk;

   imem_loader #(.DEPTH_BYTES(60), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_word    (in_word),
      .in_last    (in_last),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .word_count (word_count),
      .load_done  (load_done),
      .overflow   (overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t         exp_q[$];
   logic [7:0]  ram [0:63];
   int          errors = 0;
   int          checks = 0;
   int          writes = 0;
   logic [31:0] last_waddr = 32'd0;
   logic [31:0] exp_ptr = 32'd0;
   logic [31:0] exp_csum = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input int a);
      return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
   endfunction

   // Monitor: byte RAM model plus scoreboard pop on every write cycle.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && mem_we === 1'b1) begin
            ram[mem_waddr[5:0]] = mem_wdata;
            writes++;
            last_waddr = mem_waddr;
            chk("ready_low_in_write", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_write_addr", mem_waddr, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", mem_waddr, e.addr);
               chk("write_data", 32'(mem_wdata), 32'(e.data));
            end
         end
      end
   end

   task automatic push_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back('{exp_ptr, w[8*b +: 8]});
         exp_ptr = exp_ptr + 32'd1;
      end
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send_word(input logic [31:0] w, input logic last, input int gap);
      int cnt;
      repeat (gap) @(negedge clk);
      in_word  = w;
      in_last  = last;
      in_valid = 1'b1;
      cnt = 0;
      while (!in_ready && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
      end else begin
         push_word(w);
         exp_csum = exp_csum + w;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      exp_ptr  = 32'd0;
      exp_csum = 32'd0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!load_done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_timeout", 32'(load_done), 32'd1);
   endtask

   task automatic three_word_image();
      int cyc;
      send_word(32'h1111_1111, 1'b0, 0);
      send_word(32'h2222_2222, 1'b0, 6);
      send_word(32'h3333_3333, 1'b1, 8);
      wait_done(cyc);
      chk("img3_word0", word_at(0), 32'h1111_1111);
      chk("img3_word1", word_at(4), 32'h2222_2222);
      chk("img3_word2", word_at(8), 32'h3333_3333);
      chk("img3_count", 32'(word_count), 32'd3);
      chk("img3_ovf", 32'(overflow), 32'd0);
      chk("img3_queue", 32'(exp_q.size()), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("img3_checksum", checksum, 32'h6666_6666);
      chk("img3_checksum_model", checksum, exp_csum);
`endif
   endtask

   initial begin
      int cyc;
      int w0;
      logic seen_ready;

      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_word  = 32'd0;
      in_last  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_waddr", mem_waddr, 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd0);

      // Single word: bytes 0:23 1:20 2:A2 3:00, done one cycle after last write.
      pulse_start();
      w0 = writes;
      send_word(32'h00A2_2023, 1'b1, 0);
      wait_done(cyc);
      chk("single_done_latency", 32'(cyc), 32'd4);
      chk("single_writes", 32'(writes - w0), 32'd4);
      chk("single_count", 32'(word_count), 32'd1);
      chk("single_ovf", 32'(overflow), 32'd0);
      chk("single_in_ready", 32'(in_ready), 32'd0);
      chk("single_readback", word_at(0), 32'h00A2_2023);
      chk("single_byte1", 32'(ram[1]), 32'h20);
      chk("single_byte2", 32'(ram[2]), 32'hA2);

      // Restart from DONE, then three-word image with in_valid gaps.
      pulse_start();
      chk("restart_done", 32'(load_done), 32'd0);
      chk("restart_ovf", 32'(overflow), 32'd0);
      chk("restart_count", 32'(word_count), 32'd0);
      chk("restart_in_ready", 32'(in_ready), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("restart_checksum", checksum, 32'd0);
`endif
      three_word_image();

      // Exact fill: 15 words, last on the 15th; byte at address a holds a.
      pulse_start();
      for (int i = 0; i < 15; i++) begin
         send_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, (i == 14), i % 3);
      end
      wait_done(cyc);
      chk("fill_done", 32'(load_done), 32'd1);
      chk("fill_ovf", 32'(overflow), 32'd0);
      chk("fill_count", 32'(word_count), 32'd15);
      chk("fill_last_addr", last_waddr, 32'd59);
      chk("fill_word7", word_at(28), 32'h1F1E_1D1C);
      chk("fill_word14", word_at(56), 32'h3B3A_3938);

      // Overflow: 15 words with no last marker.
      pulse_start();
      for (int i = 0; i < 15; i++) begin
         send_word(32'hA500_0000 | 32'(i), 1'b0, 0);
      end
      wait_done(cyc);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(word_count), 32'd15);
      chk("ovf_in_ready", 32'(in_ready), 32'd0);
      chk("ovf_last_addr", last_waddr, 32'd59);
      chk("ovf_word14", word_at(56), 32'hA500_000E);
      // Offer a 16th word; it must never be accepted.
      w0 = writes;
      seen_ready = 1'b0;
      in_word  = 32'hBAD0_BAD0;
      in_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (in_ready) seen_ready = 1'b1;
      end
      in_valid = 1'b0;
      chk("ovf_16th_ready", 32'(seen_ready), 32'd0);
      chk("ovf_16th_writes", 32'(writes - w0), 32'd0);
      chk("ovf_still_done", 32'(load_done), 32'd1);

      // Restart after overflow clears flags and starts at address 0.
      pulse_start();
      chk("restart2_ovf", 32'(overflow), 32'd0);
      chk("restart2_done", 32'(load_done), 32'd0);
      chk("restart2_count", 32'(word_count), 32'd0);
      three_word_image();

      // Reset in the middle of WRITE, after two bytes written.
      pulse_start();
      send_word(32'hDEAD_BEEF, 1'b1, 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_mem_we", 32'(mem_we), 32'd0);
      chk("midrst_waddr", mem_waddr, 32'd0);
      chk("midrst_wdata", 32'(mem_wdata), 32'd0);
      chk("midrst_count", 32'(word_count), 32'd0);
      chk("midrst_done", 32'(load_done), 32'd0);
      chk("midrst_ovf", 32'(overflow), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("midrst_checksum", checksum, 32'd0);
`endif
      exp_q.delete();
      w0 = writes;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_no_writes", 32'(writes - w0), 32'd0);
      chk("midrst_idle_ready", 32'(in_ready), 32'd0);
      chk("midrst_byte0", 32'(ram[0]), 32'hEF);
      chk("midrst_byte1", 32'(ram[1]), 32'hBE);
      chk("midrst_byte2_untouched", 32'(ram[2]), 32'h11);
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
